// File: rtl/obj_det_ctrl_if.sv
// Camera timing, run control and BRAM sequencing signals of obj_det_ctrl.
// The controller takes the slave view; the capture/AXI side takes the master view.
interface obj_det_ctrl_if;
  logic        enable;
  logic        cam_vsync;
  logic        cam_pixel_valid;
  logic        recapture_req;
  logic [16:0] ref_addr;
  logic        ref_wren;
  logic        ref_bram_enable;
  logic [16:0] diff_addr;
  logic        diff_wren;
  logic        diff_bram_enable;
  logic        init_done;
  logic        frame_start;
  logic [2:0]  state_out;
  logic        short_frame;
  logic        overrun;

  modport master (
    output enable, cam_vsync, cam_pixel_valid, recapture_req,
    input  ref_addr, ref_wren, ref_bram_enable, diff_addr, diff_wren,
           diff_bram_enable, init_done, frame_start, state_out, short_frame, overrun
  );

  modport slave (
    input  enable, cam_vsync, cam_pixel_valid, recapture_req,
    output ref_addr, ref_wren, ref_bram_enable, diff_addr, diff_wren,
           diff_bram_enable, init_done, frame_start, state_out, short_frame, overrun
  );
endinterface

// File: rtl/obj_det_ctrl.sv
// Frame sequencing for the object-detection datapath: settle frames, reference
// capture into the ref BRAM, then continuous compare with read-latency-aligned diff strobes.
//
//   state       | meaning
//   IDLE        | disabled, all strobes low
//   SETTLE      | discarding SETTLE_FRAMES frames after enable
//   CAPTURE_REF | writing the current frame into the reference BRAM
//   COMPARE     | reading reference, diff strobes follow RD_LAT cycles later
module obj_det_ctrl #(
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 240,
  parameter int SETTLE_FRAMES = 4,
  parameter int RD_LAT        = 2
) (
  input logic           pixel_clk,
  input logic           resetn,
  obj_det_ctrl_if.slave bus
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam logic [16:0] FRAME_PIX_W = 17'(FRAME_PIX);
  localparam int SW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SETTLE      = 3'd1,
    CAPTURE_REF = 3'd2,
    COMPARE     = 3'd3
  } state_t;

  state_t        state, next_state, mode;
  logic          vsync_q, vs_rise, full, pix_ok, ref_stb, cmp_stb;
  logic [16:0]   pix_cnt, idx, ref_addr, ref_addr_q;
  logic [SW-1:0] settle_cnt, settle_d;
  logic          recap_q, recap_d;
  logic          short_q, over_q, short_set, over_set, flag_clr;
  logic [16:0]   pipe_addr [RD_LAT];
  logic [RD_LAT-1:0] pipe_stb;

  always_comb begin
    vs_rise    = bus.cam_vsync & ~vsync_q;
    full       = (pix_cnt == FRAME_PIX_W);
    next_state = state;
    settle_d   = settle_cnt;
    recap_d    = 1'b0;
    case (state)
      IDLE: begin
        next_state = SETTLE;
        settle_d   = SETTLE_LOAD;
      end
      SETTLE: begin
        if (vs_rise) begin
          if (settle_cnt == '0) next_state = CAPTURE_REF;
          else                  settle_d   = settle_cnt - SW'(1);
        end
      end
      CAPTURE_REF: begin
        if (vs_rise && full) next_state = COMPARE;
      end
      COMPARE: begin
        if (vs_rise && recap_q) next_state = CAPTURE_REF;
        recap_d = vs_rise ? (~recap_q & bus.recapture_req) : (recap_q | bus.recapture_req);
      end
      default: next_state = IDLE;
    endcase
    if (!bus.enable) begin
      next_state = IDLE;
      recap_d    = 1'b0;
    end
  end

  // A pixel on a vs_rise cycle belongs to the frame that starts there, so it
  // follows the next state's role rather than the current one.
  always_comb begin
    mode      = !bus.enable ? IDLE : (vs_rise ? next_state : state);
    idx       = vs_rise ? 17'd0 : pix_cnt;
    pix_ok    = bus.cam_pixel_valid && (vs_rise || !full);
    ref_stb   = pix_ok && (mode == CAPTURE_REF || mode == COMPARE);
    cmp_stb   = pix_ok && (mode == COMPARE);
    ref_addr  = ref_stb ? idx : ref_addr_q;
    flag_clr  = (state == IDLE) && bus.enable;
    short_set = bus.enable && vs_rise && !full && (state == CAPTURE_REF || state == COMPARE);
    over_set  = bus.enable && !vs_rise && bus.cam_pixel_valid && full &&
                (state == CAPTURE_REF || state == COMPARE);
  end

  always_ff @(posedge pixel_clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      pix_cnt    <= '0;
      settle_cnt <= '0;
      recap_q    <= 1'b0;
      short_q    <= 1'b0;
      over_q     <= 1'b0;
      ref_addr_q <= '0;
      pipe_stb   <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      state      <= next_state;
      vsync_q    <= bus.cam_vsync;
      settle_cnt <= settle_d;
      recap_q    <= recap_d;
      ref_addr_q <= ref_addr;
      if (vs_rise)                            pix_cnt <= {16'd0, bus.cam_pixel_valid};
      else if (bus.cam_pixel_valid && !full) pix_cnt <= pix_cnt + 17'd1;
      if (flag_clr) begin
        short_q <= 1'b0;
        over_q  <= 1'b0;
      end else begin
        if (short_set) short_q <= 1'b1;
        if (over_set)  over_q  <= 1'b1;
      end
      pipe_addr[0] <= ref_addr;
      pipe_stb[0]  <= cmp_stb;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_stb[i]  <= pipe_stb[i-1];
      end
      // Flush so no diff write can trail a disable.
      if (!bus.enable) pipe_stb <= '0;
    end
  end

  assign bus.ref_addr         = ref_addr;
  assign bus.ref_wren         = ref_stb && (mode == CAPTURE_REF);
  assign bus.ref_bram_enable  = ref_stb;
  assign bus.diff_addr        = pipe_addr[RD_LAT-1];
  assign bus.diff_wren        = pipe_stb[RD_LAT-1] & bus.enable;
  assign bus.diff_bram_enable = pipe_stb[RD_LAT-1] & bus.enable;
  assign bus.init_done        = (mode == COMPARE);
  assign bus.frame_start      = bus.enable && vs_rise && (state == COMPARE) && (next_state == COMPARE);
  assign bus.state_out        = state;
  assign bus.short_frame      = short_q;
  assign bus.overrun          = over_q;

endmodule

// File: tb/tb_obj_det_ctrl.sv
// Bench for obj_det_ctrl: frame-level vector table, directed corner sequences and
// random frames, all checked every cycle against a frame-rule reference model.
module tb_obj_det_ctrl;
  localparam int H = 8, V = 4, SF = 2, RL = 2, FP = H * V;

  logic pixel_clk = 1'b0;
  logic resetn;
  obj_det_ctrl_if bus();

  obj_det_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .SETTLE_FRAMES(SF), .RD_LAT(RL)) dut (
    .pixel_clk(pixel_clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int ref_addr; bit ref_wren; bit ref_en;
    int diff_addr; bit diff_wren; bit diff_en;
    bit init; bit fs; int st; bit sh; bit ov;
  } outs_t;
  outs_t e, a;

  // Reference model: frame role per phase number (0 idle, 1 settle, 2 capture, 3 compare).
  typedef struct { int addr; bit stb; } dq_t;
  dq_t dq[$];
  int  m_phase, m_settled, m_cnt, m_ref_addr;
  bit  m_vs_prev, m_pend, m_short, m_over;

  task automatic model_reset();
    m_phase = 0; m_settled = 0; m_cnt = 0; m_ref_addr = 0;
    m_vs_prev = 0; m_pend = 0; m_short = 0; m_over = 0;
    dq = {};
    repeat (RL) dq.push_back('{0, 1'b0});
  endtask

  task automatic model_step(bit en, bit vs, bit pv, bit req);
    bit rise, acc, stb;
    int nph, fph, idx;
    rise = vs && !m_vs_prev;
    nph  = m_phase;
    if (!en) nph = 0;
    else case (m_phase)
      0: nph = 1;
      1: if (rise && m_settled + 1 == SF) nph = 2;
      2: if (rise && m_cnt == FP) nph = 3;
      3: if (rise && m_pend) nph = 2;
      default: nph = 0;
    endcase
    fph = !en ? 0 : (rise ? nph : m_phase);
    idx = rise ? 0 : m_cnt;
    acc = pv && (idx < FP);
    stb = acc && (fph == 2 || fph == 3);
    e.ref_en    = stb;
    e.ref_wren  = stb && fph == 2;
    e.ref_addr  = stb ? idx : m_ref_addr;
    e.diff_addr = dq[0].addr;
    e.diff_wren = en && dq[0].stb;
    e.diff_en   = en && dq[0].stb;
    e.init      = (fph == 3);
    e.fs        = en && rise && m_phase == 3 && nph == 3;
    e.st        = m_phase;
    e.sh        = m_short;
    e.ov        = m_over;
    if (en && m_phase == 0) begin m_short = 0; m_over = 0; m_settled = 0; end
    if (en && rise && m_phase == 1) m_settled++;
    if (en && rise && (m_phase == 2 || m_phase == 3) && m_cnt < FP) m_short = 1;
    if (en && !rise && pv && m_cnt == FP && (m_phase == 2 || m_phase == 3)) m_over = 1;
    m_cnt = rise ? int'(pv) : (acc ? m_cnt + 1 : m_cnt);
    if (!en || m_phase != 3) m_pend = 0;
    else if (rise)           m_pend = !m_pend && req;
    else                     m_pend = m_pend || req;
    dq.delete(0);
    dq.push_back('{e.ref_addr, stb && fph == 3});
    if (!en) foreach (dq[i]) dq[i].stb = 1'b0;
    m_ref_addr = e.ref_addr;
    m_phase    = nph;
    m_vs_prev  = vs;
  endtask

  task automatic sample();
    a.ref_addr  = int'(bus.ref_addr);
    a.ref_wren  = bus.ref_wren;
    a.ref_en    = bus.ref_bram_enable;
    a.diff_addr = int'(bus.diff_addr);
    a.diff_wren = bus.diff_wren;
    a.diff_en   = bus.diff_bram_enable;
    a.init      = bus.init_done;
    a.fs        = bus.frame_start;
    a.st        = int'(bus.state_out);
    a.sh        = bus.short_frame;
    a.ov        = bus.overrun;
  endtask

  task automatic compare_all();
    check("ref_addr", a.ref_addr, e.ref_addr);
    check("ref_wren", a.ref_wren, e.ref_wren);
    check("ref_bram_enable", a.ref_en, e.ref_en);
    check("diff_addr", a.diff_addr, e.diff_addr);
    check("diff_wren", a.diff_wren, e.diff_wren);
    check("diff_bram_enable", a.diff_en, e.diff_en);
    check("init_done", a.init, e.init);
    check("frame_start", a.fs, e.fs);
    check("state_out", a.st, e.st);
    check("short_frame", a.sh, e.sh);
    check("overrun", a.ov, e.ov);
  endtask

  bit track = 0;
  int f_en, f_wr;

  task automatic cycle(bit en, bit vs, bit pv, bit req);
    @(negedge pixel_clk);
    bus.enable = en; bus.cam_vsync = vs; bus.cam_pixel_valid = pv; bus.recapture_req = req;
    #1;
    model_step(en, vs, pv, req);
    sample();
    compare_all();
    if (track && a.ref_en) begin
      check("strobe_addr_seq", a.ref_addr, f_en);
      f_en++;
    end
    if (track && a.ref_wren) f_wr++;
  endtask

  task automatic async_reset();
    @(negedge pixel_clk);
    #2;
    resetn = 1'b0;
    bus.enable = 0; bus.cam_vsync = 0; bus.cam_pixel_valid = 0; bus.recapture_req = 0;
    #1;
    model_reset();
    e = '{default: 0};
    sample();
    compare_all();
    @(negedge pixel_clk);
    #2;
    resetn = 1'b1;
  endtask

  task automatic run_frame(int npix, bit req, output bit b_init, output bit b_fs, output int st_after);
    f_en = 0; f_wr = 0; track = 1;
    cycle(1, 1, 0, 0);
    b_init = a.init; b_fs = a.fs;
    cycle(1, 1, 0, 0);
    st_after = a.st;
    for (int i = 0; i < npix; i++) begin
      repeat ($urandom_range(0, 2)) cycle(1, 0, 0, 0);
      cycle(1, 0, 1, req && (i == npix / 2));
    end
    repeat (3) cycle(1, 0, 0, 0);
    track = 0;
  endtask

  typedef struct {
    int npix; bit req;
    bit x_init; bit x_fs; int x_state; int x_wr; int x_en; bit x_sh; bit x_ov;
  } frec_t;
  frec_t tbl[10];

  initial begin
    bit b_init, b_fs;
    int st_after, dw;

    tbl[0] = '{32, 0, 0, 0, 1,  0,  0, 0, 0};
    tbl[1] = '{32, 0, 0, 0, 2, 32, 32, 0, 0};
    tbl[2] = '{32, 0, 1, 0, 3,  0, 32, 0, 0};
    tbl[3] = '{30, 0, 1, 1, 3,  0, 30, 0, 0};
    tbl[4] = '{34, 0, 1, 1, 3,  0, 32, 1, 1};
    tbl[5] = '{32, 1, 1, 1, 3,  0, 32, 1, 1};
    tbl[6] = '{30, 0, 0, 0, 2, 30, 30, 1, 1};
    tbl[7] = '{32, 0, 0, 0, 2, 32, 32, 1, 1};
    tbl[8] = '{32, 0, 1, 0, 3,  0, 32, 1, 1};
    tbl[9] = '{32, 0, 1, 1, 3,  0, 32, 1, 1};

    resetn = 1'b1;
    bus.enable = 0; bus.cam_vsync = 0; bus.cam_pixel_valid = 0; bus.recapture_req = 0;
    #1 resetn = 1'b0;
    #1;
    model_reset();
    e = '{default: 0};
    sample();
    compare_all();
    @(negedge pixel_clk);
    #2 resetn = 1'b1;

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("enter_settle", a.st, 1);

    for (int r = 0; r < 10; r++) begin
      run_frame(tbl[r].npix, tbl[r].req, b_init, b_fs, st_after);
      check("tbl_boundary_init_done", b_init, tbl[r].x_init);
      check("tbl_boundary_frame_start", b_fs, tbl[r].x_fs);
      check("tbl_state_after_boundary", st_after, tbl[r].x_state);
      check("tbl_ref_wren_count", f_wr, tbl[r].x_wr);
      check("tbl_ref_strobe_count", f_en, tbl[r].x_en);
      check("tbl_short_frame", a.sh, tbl[r].x_sh);
      check("tbl_overrun", a.ov, tbl[r].x_ov);
      if (tbl[r].x_en > 0) check("tbl_last_ref_addr", a.ref_addr, tbl[r].x_en - 1);
    end

    // Pixel coinciding with the compare-mode boundary is pixel 0 of the new frame.
    cycle(1, 1, 1, 0);
    check("coinc_strobe", a.ref_en, 1);
    check("coinc_addr", a.ref_addr, 0);
    check("coinc_frame_start", a.fs, 1);
    cycle(1, 1, 1, 0);
    check("coinc_next_addr", a.ref_addr, 1);
    repeat (30) cycle(1, 0, 1, 0);
    check("coinc_last_addr", a.ref_addr, 31);
    repeat (3) cycle(1, 0, 0, 0);

    // Disable mid compare frame: strobes drop at once, no diff write afterwards.
    cycle(1, 1, 0, 0);
    repeat (5) cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);
    check("dis_ref_strobe", a.ref_en, 0);
    check("dis_init_done", a.init, 0);
    check("dis_diff_wren", a.diff_wren, 0);
    dw = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 0, 0);
      if (k == 0) check("dis_state_idle", a.st, 0);
      dw += int'(a.diff_wren);
    end
    check("dis_no_diff_after_flush", dw, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("reenable_settle", a.st, 1);
    check("reenable_short_clr", a.sh, 0);
    check("reenable_overrun_clr", a.ov, 0);

    // Async reset in the middle of a reference capture.
    run_frame(32, 0, b_init, b_fs, st_after);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("cap_state", a.st, 2);
    repeat (10) cycle(1, 0, 1, 0);
    check("cap_wren_before_reset", a.ref_wren, 1);
    async_reset();
    cycle(0, 0, 0, 0);

    for (int f = 0; f < 40; f++) begin
      int np, r, vl;
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 4)) cycle(0, 0, 1'($urandom_range(0, 1)), 0);
      r  = int'($urandom_range(0, 9));
      np = (r < 6) ? FP : (r == 6) ? FP - 2 : (r == 7) ? FP + 2 : int'($urandom_range(0, FP + 3));
      vl = int'($urandom_range(1, 3));
      for (int k = 0; k < vl; k++) cycle(1, 1, (k == 0) && ($urandom_range(0, 3) == 0), 0);
      for (int i = 0; i < np; i++) begin
        if ($urandom_range(0, 2) == 0) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, $urandom_range(0, 15) == 0);
      end
      repeat (2) cycle(1, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
